// File: rtl/pon_sched_pkg.sv
// Shared types and defaults for the upstream PON burst scheduler.
package pon_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PREAMBLE = 2'b01,
    ST_PAYLOAD  = 2'b10,
    ST_GAP      = 2'b11
  } sched_state_e;

  localparam int unsigned DEF_MIN_GAP = 2;

endpackage

// File: rtl/pon_sched_cfg_check.sv
// Burst config validity check on the live inputs, plus the per-period shadow copy.
module pon_sched_cfg_check
  import pon_sched_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [CNT_W-1:0] p_in,
  input  logic [CNT_W-1:0] b_in,
  input  logic [CNT_W-1:0] t_in,
  input  logic             b2b_in,
  output logic             cfg_valid,
  output logic [CNT_W-1:0] p_sh,
  output logic [CNT_W-1:0] b_sh,
  output logic [CNT_W-1:0] t_sh,
  output logic             b2b_sh
);

  // Two guard bits keep P+B+MIN_GAP from wrapping.
  localparam int EW = CNT_W + 2;

  logic [EW-1:0] pb_sum;
  logic [EW-1:0] t_ext;

  assign pb_sum = EW'(p_in) + EW'(b_in);
  assign t_ext  = EW'(t_in);

  always_comb begin
    cfg_valid = 1'b1;
    if (t_in == '0)                                      cfg_valid = 1'b0;
    if (pb_sum > t_ext)                                  cfg_valid = 1'b0;
    if (!b2b_in && (pb_sum + EW'(MIN_GAP) > t_ext))      cfg_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_sh   <= '0;
      b_sh   <= '0;
      t_sh   <= '0;
      b2b_sh <= 1'b0;
    end else if (sample) begin
      p_sh   <= p_in;
      b_sh   <= b_in;
      t_sh   <= t_in;
      b2b_sh <= b2b_in;
    end
  end

endmodule

// File: rtl/pon_burst_scheduler.sv
// Upstream PON burst sequencer: per-period TX enable, preamble and payload windows.
module pon_burst_scheduler
  import pon_sched_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int MIN_GAP = DEF_MIN_GAP,
  parameter int BCNT_W  = 16
) (
  input  logic              hb0_gtwiz_userclk_tx_usrclk2_int,
  input  logic              sys_reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  preamble_length,
  input  logic [CNT_W-1:0]  burst_length,
  input  logic [CNT_W-1:0]  burst_period,
  input  logic              b2b_enable,
  input  logic              data_valid,
  output logic              tx_enable,
  output logic              preamble_active,
  output logic              data_req,
  output logic              burst_start,
  output logic              burst_end,
  output logic              underrun,
  output logic              config_error,
  output logic [BCNT_W-1:0] burst_count,
  output logic [1:0]        state
);

  localparam int EW = CNT_W + 2;

  sched_state_e     st_q, st_d;
  logic [CNT_W-1:0] pc_q;
  logic [CNT_W-1:0] p_sh, b_sh, t_sh;
  logic             b2b_sh;
  logic             cfg_valid;
  logic             period_end, boundary, sample;
  logic [EW-1:0]    pc_nxt, pb_end_sh;

  assign pc_nxt     = EW'(pc_q) + EW'(1);
  assign pb_end_sh  = EW'(p_sh) + EW'(b_sh);
  assign period_end = (st_q != ST_IDLE) && (pc_q == t_sh - CNT_W'(1));
  // Period start: idle with a run request, or the last cycle of any period.
  assign boundary   = (st_q == ST_IDLE) || period_end;
  assign sample     = boundary && enable;

  pon_sched_cfg_check #(.CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) u_cfg (
    .clk       (hb0_gtwiz_userclk_tx_usrclk2_int),
    .rst       (sys_reset),
    .sample    (sample),
    .p_in      (preamble_length),
    .b_in      (burst_length),
    .t_in      (burst_period),
    .b2b_in    (b2b_enable),
    .cfg_valid (cfg_valid),
    .p_sh      (p_sh),
    .b_sh      (b_sh),
    .t_sh      (t_sh),
    .b2b_sh    (b2b_sh)
  );

  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int) begin
    if (sys_reset) st_q <= ST_IDLE;
    else           st_q <= st_d;
  end

  // Entry decisions use the live config, which is captured this same cycle.
  always_comb begin
    st_d = st_q;
    if (boundary) begin
      if (enable && cfg_valid) begin
        if (burst_length == '0)         st_d = ST_GAP;
        else if (preamble_length == '0) st_d = ST_PAYLOAD;
        else                            st_d = ST_PREAMBLE;
      end else begin
        st_d = ST_IDLE;
      end
    end else begin
      case (st_q)
        ST_PREAMBLE: if (pc_nxt == EW'(p_sh)) st_d = ST_PAYLOAD;
        ST_PAYLOAD:  if (pc_nxt == pb_end_sh) st_d = ST_GAP;
        default:     ;
      endcase
    end
  end

  always_comb begin
    tx_enable       = 1'b0;
    preamble_active = 1'b0;
    data_req        = 1'b0;
    burst_start     = 1'b0;
    burst_end       = 1'b0;
    case (st_q)
      ST_PREAMBLE: begin
        tx_enable       = 1'b1;
        preamble_active = 1'b1;
        burst_start     = (pc_q == '0);
      end
      ST_PAYLOAD: begin
        tx_enable   = 1'b1;
        data_req    = 1'b1;
        burst_start = (pc_q == '0);
        burst_end   = (pc_nxt == pb_end_sh);
      end
      ST_GAP:  tx_enable = b2b_sh && (b_sh != '0);
      default: ;
    endcase
  end

  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int) begin
    if (sys_reset) begin
      pc_q         <= '0;
      config_error <= 1'b0;
      burst_count  <= '0;
      underrun     <= 1'b0;
    end else begin
      pc_q <= boundary ? '0 : pc_q + CNT_W'(1);
      if (sample)                  config_error <= !cfg_valid;
      if (burst_end)               burst_count  <= burst_count + BCNT_W'(1);
      if (data_req && !data_valid) underrun     <= 1'b1;
    end
  end

  assign state = st_q;

endmodule

// File: doc/pon_burst_scheduler.md
Name: pon_burst_scheduler

Overview:
- Sequences the upstream PON burst transmitter from the runtime burst controls: preamble length, burst length, burst period and back-to-back mode.
- Each period it generates the laser/TX enable window, the preamble window and the payload request window, plus start/end strobes and status.
- Sits between the VIO/config registers and the burst framer/GT TX datapath, on the TX user clock.

Parameters:
- CNT_W, 32, width of the length/period config inputs and internal counters.
- MIN_GAP, 2, minimum off cycles required between bursts when back-to-back is disabled.
- BCNT_W, 16, width of the burst counter (wraps).

Ports:
- hb0_gtwiz_userclk_tx_usrclk2_int  in  1  sole clock; all logic rising-edge.
- sys_reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- preamble_length  in  CNT_W  preamble cycles per burst (P).
- burst_length  in  CNT_W  payload cycles per burst (B).
- burst_period  in  CNT_W  cycles per period (T).
- b2b_enable  in  1  back-to-back mode: tx_enable is held high through the gap.
- data_valid  in  1  framer has payload word this cycle.
- tx_enable  out  1  laser/burst-mode TX enable.
- preamble_active  out  1  preamble window; framer sends preamble pattern.
- data_req  out  1  payload window; framer must present a word.
- burst_start  out  1  one-cycle pulse on the first cycle of the burst.
- burst_end  out  1  one-cycle pulse on the last payload cycle.
- underrun  out  1  sticky: data_req high while data_valid is low; cleared only by reset.
- config_error  out  1  latched config is invalid; updated at each period start.
- burst_count  out  BCNT_W  completed bursts, wraps modulo 2^BCNT_W.
- state  out  2  00 IDLE, 01 PREAMBLE, 10 PAYLOAD, 11 GAP (for VIO probe).

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shadow config 0. Applies immediately, including mid-burst; no graceful close.
- Shadow config: P/B/T/b2b are sampled only on a period-start cycle (IDLE with enable=1, or the last GAP cycle with enable=1). Input changes mid-period have no effect until the next period.
- Validity check on the sampled values, using CNT_W+2 bit arithmetic so there is no overflow:
  - invalid if T==0;
  - invalid if P+B > T;
  - invalid if b2b=0 and P+B+MIN_GAP > T.
  - If invalid: config_error=1, stay in or return to IDLE, all windows low, re-check every cycle while enable=1.
  - If valid: config_error=0.
- Period counter pc runs 0..T-1 from the period start, with windows [P, P+B) etc. taken relative to it.
- IDLE -> PREAMBLE when valid and P>0; -> PAYLOAD when P==0 and B>0; -> GAP when B==0.
- When B==0 there is no burst that period: tx_enable, burst_start, burst_end and data_req stay low, and burst_count is unchanged.
- Windows are registered outputs, asserted in the same cycle the state is entered:
  - preamble_active=1 for pc in [0,P);
  - data_req=1 for pc in [P,P+B);
  - tx_enable=1 for pc in [0,P+B), and also for [P+B,T) when b2b=1.
- burst_start=1 at pc==0 when B>0.
- burst_end=1 at pc==P+B-1 when B>0; burst_count increments in the same cycle.
- GAP lasts until pc==T-1. Then:
  - if enable=1, re-sample config and start the next period with no idle cycle (back-to-back periods are contiguous);
  - if enable=0, go to IDLE with all outputs low.
- If enable drops mid-period, the current period completes; there is no truncated burst.
- In b2b mode with P+B==T, tx_enable stays continuously high across periods and burst_start/burst_end still pulse every period.
- Simultaneous burst_end and last-cycle-of-period (gap of 0 in b2b): both actions occur; the next state is taken from the new config.

Decomposition:
- Package pon_sched_pkg: state enum (IDLE/PREAMBLE/PAYLOAD/GAP encodings) and default MIN_GAP constant.
- One sub-module, pon_sched_cfg_check: combinational validity check plus shadow-register capture. The FSM and counters stay in the top.

Test Plan:
- P=4, B=10, T=20, b2b=0, enable held:
  - preamble_active on pc 0-3, data_req on 4-13, tx_enable on 0-13;
  - burst_start at pc0, burst_end at pc13;
  - period repeats every 20 cycles, burst_count increments 1 per period.
- Same config with b2b=1, then P=2, B=18, T=20 b2b=1: tx_enable never drops after the first burst_start; burst_end every 20 cycles.
- Invalid configs:
  - T=0 -> config_error=1, all windows low;
  - P=10, B=10, T=21, b2b=0 -> config_error=1;
  - change to T=22 -> error clears and the burst starts on the next cycle.
- Change B from 10 to 5 at pc=6 of a period: current period keeps data_req through pc13; the next period uses B=5.
- Deassert enable at pc=5: burst completes, then IDLE after pc19.
- sys_reset asserted at pc=8 mid-payload: next cycle all outputs 0 and state IDLE.
- data_valid held low for one cycle during data_req: underrun=1 and stays set; cleared only by sys_reset.
- P=0, B=0, T=8: no tx_enable and no strobes; burst_count stays at 0.
